// File: rtl/wb_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer_if
// Bundles the writeback-capture and drain signals of wb_trace_buffer.
//   master : the core / bench side; drives writebacks, done and rd_ready,
//            observes the head entry and the status outputs.
//   slave  : the trace buffer itself.
// Signals
//   wb_valid, wb_reg, wb_data : register-file writeback from the core
//   done                      : core program-complete flag
//   rd_ready                  : consumer accepts the head entry
//   rd_valid, rd_data,
//   rd_reg, rd_cycle          : show-ahead head entry (zero while empty)
//   count, full, overflow,
//   halted, cycle_cnt         : status
// ---------------------------------------------------------------------------
interface wb_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ADDR_W = 4,
    parameter int CYC_W  = 16
);
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              done;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [REG_W-1:0]  rd_reg;
    logic [CYC_W-1:0]  rd_cycle;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;
    logic              halted;
    logic [CYC_W-1:0]  cycle_cnt;

    modport master (
        output wb_valid, wb_reg, wb_data, done, rd_ready,
        input  rd_valid, rd_data, rd_reg, rd_cycle,
        input  count, full, overflow, halted, cycle_cnt
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, done, rd_ready,
        output rd_valid, rd_data, rd_reg, rd_cycle,
        output count, full, overflow, halted, cycle_cnt
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
// Observes the single-cycle core's register-file writebacks and records each
// one as {cycle stamp, dest reg, data} in a show-ahead FIFO until the core
// raises done. Entries are drained through a valid/ready interface, in both
// RUN and HALTED states.
// Ports
//   clk   : rising-edge clock, shared with the core
//   reset : asynchronous, active-low; clears all control state
//   bus   : wb_trace_buffer_if.slave (writeback in, head entry + status out)
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CYC_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    wb_trace_buffer_if.slave bus
);
    localparam int              ENTRY_W  = CYC_W + REG_W + DATA_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;

    // Full/empty come from the occupancy count so the pointers can simply
    // wrap modulo DEPTH without an extra lap bit.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cyc_d      = cyc_q;
        push       = 1'b0;
        pop        = !empty && bus.rd_ready;

        if (state_q == RUN) begin
            // Saturate rather than wrap so late stamps stay monotonic.
            if (cyc_q != '1) begin
                cyc_d = cyc_q + 1'b1;
            end
            // The writeback that accompanies done is still captured below.
            if (bus.done) begin
                state_d = HALTED;
            end
            if (bus.wb_valid) begin
                // A pop in the same cycle frees the slot of a full FIFO.
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cyc_q      <= cyc_d;
        end
    end

    // Storage is not reset; the output mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cyc_q, bus.wb_reg, bus.wb_data};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.rd_valid  = !empty;
    assign bus.rd_data   = empty ? '0 : head[DATA_W-1:0];
    assign bus.rd_reg    = empty ? '0 : head[DATA_W +: REG_W];
    assign bus.rd_cycle  = empty ? '0 : head[DATA_W+REG_W +: CYC_W];
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.halted    = (state_q == HALTED);
    assign bus.cycle_cnt = cyc_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    typedef struct packed {
        logic [15:0] cyc;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   tcyc   = 0;
    bit   thalt  = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.DATA_W(32), .REG_W(5), .ADDR_W(4), .CYC_W(16)) ifc ();
    wb_trace_buffer_if #(.DATA_W(32), .REG_W(5), .ADDR_W(4), .CYC_W(4))  ifs ();

    wb_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(16), .ADDR_W(4), .CYC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    wb_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(16), .ADDR_W(4), .CYC_W(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock edge; the bench's own cycle count follows the RUN/HALTED rule.
    task automatic step();
        @(posedge clk);
        if (!thalt) begin
            if (tcyc != 65535) tcyc++;
            if (ifc.done) thalt = 1'b1;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d, input bit captured);
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = r;
        ifc.wb_data  = d;
        if (captured) sb.push_back({tcyc[15:0], r, d});
    endtask

    task automatic idle_inputs();
        ifc.wb_valid = 1'b0; ifc.wb_reg = '0; ifc.wb_data = '0;
        ifc.done = 1'b0;     ifc.rd_ready = 1'b0;
        ifs.wb_valid = 1'b0; ifs.wb_reg = '0; ifs.wb_data = '0;
        ifs.done = 1'b0;     ifs.rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tcyc  = 0;
        thalt = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head entry is compared with the
    // oldest expected capture.
    always @(negedge clk) begin
        exp_t e;
        if (reset && ifc.rd_valid && ifc.rd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=reg%0d/%0h expected=no entry",
                         ifc.rd_reg, ifc.rd_data);
            end else begin
                e = sb.pop_front();
                chk("pop_data",  ifc.rd_data,  e.d);
                chk("pop_reg",   32'(ifc.rd_reg),   32'(e.r));
                chk("pop_cycle", 32'(ifc.rd_cycle), 32'(e.cyc));
            end
        end
    end

    initial begin
        idle_inputs();
        #2;
        // Reset state
        chk("rst_count",    32'(ifc.count), 0);
        chk("rst_rd_valid", 32'(ifc.rd_valid), 0);
        chk("rst_rd_data",  ifc.rd_data, 0);
        chk("rst_cycle",    32'(ifc.cycle_cnt), 0);
        chk("rst_halted",   32'(ifc.halted), 0);
        chk("rst_overflow", 32'(ifc.overflow), 0);
        do_reset();

        // Five writebacks, then drain (one extra rd_ready while empty)
        for (int k = 1; k <= 5; k++) begin
            push(5'(k), 32'h100 + 32'(k), 1'b1);
            step();
        end
        ifc.wb_valid = 1'b0;
        chk("t1_count",      32'(ifc.count), 5);
        chk("t1_head_cycle", 32'(ifc.rd_cycle), 0);
        chk("t1_head_reg",   32'(ifc.rd_reg), 1);
        chk("t1_head_data",  ifc.rd_data, 32'h101);
        chk("t1_cycle_cnt",  32'(ifc.cycle_cnt), 5);
        ifc.rd_ready = 1'b1;
        steps(6);
        ifc.rd_ready = 1'b0;
        chk("t1_count_end", 32'(ifc.count), 0);
        chk("t1_rd_valid",  32'(ifc.rd_valid), 0);
        chk("t1_rd_data0",  ifc.rd_data, 0);
        chk("t1_sb_empty",  sb.size(), 0);

        // Fill 16, 17th dropped while full
        do_reset();
        for (int k = 0; k < 16; k++) begin
            push(5'(k), 32'hA000 + 32'(k), 1'b1);
            step();
        end
        push(5'd17, 32'hA0FF, 1'b0);
        step();
        ifc.wb_valid = 1'b0;
        chk("t2_count",    32'(ifc.count), 16);
        chk("t2_full",     32'(ifc.full), 1);
        chk("t2_overflow", 32'(ifc.overflow), 1);
        ifc.rd_ready = 1'b1;
        steps(16);
        ifc.rd_ready = 1'b0;
        chk("t2_drained",  32'(ifc.count), 0);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_sticky",   32'(ifc.overflow), 1);

        // Fill 16, 17th with a simultaneous pop
        do_reset();
        for (int k = 0; k < 16; k++) begin
            push(5'(k), 32'hB000 + 32'(k), 1'b1);
            step();
        end
        push(5'd17, 32'hB0FF, 1'b1);
        ifc.rd_ready = 1'b1;
        step();
        ifc.wb_valid = 1'b0;
        ifc.rd_ready = 1'b0;
        chk("t2b_overflow", 32'(ifc.overflow), 0);
        chk("t2b_count",    32'(ifc.count), 16);
        chk("t2b_full",     32'(ifc.full), 1);
        ifc.rd_ready = 1'b1;
        steps(16);
        ifc.rd_ready = 1'b0;
        chk("t2b_drained",  32'(ifc.count), 0);
        chk("t2b_sb_empty", sb.size(), 0);

        // done together with the final writeback at cycle 7
        do_reset();
        steps(7);
        chk("t3_pre_cycle", 32'(ifc.cycle_cnt), 7);
        push(5'd2, 32'hDEAD, 1'b1);
        ifc.done = 1'b1;
        step();
        ifc.done = 1'b0;
        chk("t3_halted", 32'(ifc.halted), 1);
        chk("t3_cycle",  32'(ifc.cycle_cnt), 8);
        push(5'd3, 32'hBEEF, 1'b0);
        steps(3);
        ifc.wb_valid = 1'b0;
        chk("t3_frozen",     32'(ifc.cycle_cnt), 8);
        chk("t3_count",      32'(ifc.count), 1);
        chk("t3_still_halt", 32'(ifc.halted), 1);
        ifc.rd_ready = 1'b1;
        step();
        ifc.rd_ready = 1'b0;
        chk("t3_drained", 32'(ifc.count), 0);

        // Push and pop every cycle for 40 cycles
        do_reset();
        ifc.rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(5'(i % 32), 32'h2000 + 32'(i), 1'b1);
            step();
            chk("t4_count_le1", 32'(ifc.count <= 1), 1);
        end
        ifc.wb_valid = 1'b0;
        step();
        ifc.rd_ready = 1'b0;
        chk("t4_count",    32'(ifc.count), 0);
        chk("t4_overflow", 32'(ifc.overflow), 0);
        chk("t4_sb_empty", sb.size(), 0);

        // 4-bit cycle counter saturates at 15
        do_reset();
        steps(15);
        chk("t5_cyc15", 32'(ifs.cycle_cnt), 15);
        steps(3);
        chk("t5_cyc_sat", 32'(ifs.cycle_cnt), 15);
        ifs.wb_valid = 1'b1; ifs.wb_reg = 5'd7; ifs.wb_data = 32'h77;
        step();
        ifs.wb_data = 32'h78;
        step();
        ifs.wb_valid = 1'b0;
        chk("t5_cyc_end",  32'(ifs.cycle_cnt), 15);
        chk("t5_count",    32'(ifs.count), 2);
        chk("t5_stamp0",   32'(ifs.rd_cycle), 15);
        chk("t5_data0",    ifs.rd_data, 32'h77);
        ifs.rd_ready = 1'b1;
        step();
        ifs.rd_ready = 1'b0;
        chk("t5_stamp1",   32'(ifs.rd_cycle), 15);
        chk("t5_data1",    ifs.rd_data, 32'h78);

        // Asynchronous reset with 9 entries, overflow set, HALTED
        do_reset();
        for (int k = 0; k < 17; k++) begin
            push(5'(k), 32'hC000 + 32'(k), k < 16);
            step();
        end
        ifc.wb_valid = 1'b0;
        ifc.done = 1'b1;
        step();
        ifc.done = 1'b0;
        chk("t6_halted",   32'(ifc.halted), 1);
        chk("t6_overflow", 32'(ifc.overflow), 1);
        ifc.rd_ready = 1'b1;
        steps(7);
        ifc.rd_ready = 1'b0;
        chk("t6_count9", 32'(ifc.count), 9);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_rst_count",    32'(ifc.count), 0);
        chk("t6_rst_rd_valid", 32'(ifc.rd_valid), 0);
        chk("t6_rst_overflow", 32'(ifc.overflow), 0);
        chk("t6_rst_halted",   32'(ifc.halted), 0);
        chk("t6_rst_cycle",    32'(ifc.cycle_cnt), 0);
        chk("t6_rst_rd_data",  ifc.rd_data, 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tcyc  = 0;
        thalt = 1'b0;
        step();
        chk("t6_first_edge", 32'(ifc.cycle_cnt), 1);
        chk("t6_run",        32'(ifc.halted), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
